// File: rtl/pio_led_pkg.sv
// Shared constants and types for the parametrised LED/GPIO PIO.
package pio_led_pkg;

  typedef logic [31:0] word_t;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_SET        = 3'd1;
  localparam logic [2:0] ADDR_CLEAR      = 3'd2;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd3;
  localparam logic [2:0] ADDR_BLINK_DIV  = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK   = 3'd5;
  localparam logic [2:0] ADDR_EDGE_CAP   = 3'd6;
  localparam logic [2:0] ADDR_DUTY       = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_led_ctrl_if.sv
// Avalon-MM slave bus bundle for pio_led_ctrl (fixed read latency 1, no waitrequest).
interface pio_led_ctrl_if;
  import pio_led_pkg::*;

  logic [2:0] address;
  logic       read;
  logic       write;
  word_t      writedata;
  word_t      readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/pio_edge_capture.sv
// Two-flop synchroniser, edge detector and W1C edge-capture register.
module pio_edge_capture
  import pio_led_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] gpio_in,
  input  logic [IN_W-1:0] clr_i,
  output logic [IN_W-1:0] sync_o,
  output logic [IN_W-1:0] cap_o
);

  logic [IN_W-1:0] sync1_q, sync2_q, prev_q, cap_q;
  logic [IN_W-1:0] edge_hit, cap_d;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_hit = ~sync2_q & prev_q;
      EDGE_ANY:  edge_hit = sync2_q ^ prev_q;
      default:   edge_hit = sync2_q & ~prev_q;
    endcase
    // A fresh edge outranks a simultaneous W1C clear of the same bit.
    cap_d = (cap_q & ~clr_i) | edge_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cap_q   <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cap_q   <= cap_d;
    end
  end

  assign sync_o = sync2_q;
  assign cap_o  = cap_q;

endmodule

// File: rtl/pio_led_ctrl.sv
// LED output register with set/clear, blink engine and input edge-capture IRQ.
// Optional PWM dimming on address 7 when PIO_PWM_EN is defined.
module pio_led_ctrl
  import pio_led_pkg::*;
#(
  parameter int               OUT_W     = 8,
  parameter int               IN_W      = 4,
  parameter logic [OUT_W-1:0] RESET_OUT = '0,
  parameter int               EDGE_TYPE = EDGE_RISE,
  parameter int               DIV_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  pio_led_ctrl_if.slave    bus,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] led,
  output logic             irq
);

  logic [OUT_W-1:0] out_q, out_d, mask_q, mask_d, led_q, led_d, blink_out;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic             phase_q, phase_d, irq_q, irq_d;
  logic [IN_W-1:0]  irqm_q, irqm_d, clr, sync, cap;
  word_t            rdata_q, rdata_d;
`ifdef PIO_PWM_EN
  logic [7:0]       duty_q, duty_d, pwm_q, pwm_d;
`endif

  pio_edge_capture #(.IN_W(IN_W), .EDGE_TYPE(EDGE_TYPE)) u_cap (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .clr_i   (clr),
    .sync_o  (sync),
    .cap_o   (cap)
  );

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    div_d  = div_q;
    irqm_d = irqm_q;
    clr    = '0;
`ifdef PIO_PWM_EN
    duty_d = duty_q;
    pwm_d  = pwm_q + 8'd1;
`endif
    if (bus.write) begin
      case (bus.address)
        ADDR_DATA:       out_d  = bus.writedata[OUT_W-1:0];
        ADDR_SET:        out_d  = out_q | bus.writedata[OUT_W-1:0];
        ADDR_CLEAR:      out_d  = out_q & ~bus.writedata[OUT_W-1:0];
        ADDR_BLINK_MASK: mask_d = bus.writedata[OUT_W-1:0];
        ADDR_BLINK_DIV:  div_d  = bus.writedata[DIV_W-1:0];
        ADDR_IRQ_MASK:   irqm_d = bus.writedata[IN_W-1:0];
        ADDR_EDGE_CAP:   clr    = bus.writedata[IN_W-1:0];
`ifdef PIO_PWM_EN
        ADDR_DUTY:       duty_d = bus.writedata[7:0];
`endif
        default: ;
      endcase
    end

    cnt_d   = cnt_q + DIV_W'(1);
    phase_d = phase_q;
    if ((bus.write && bus.address == ADDR_BLINK_DIV) || div_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q - DIV_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end

    blink_out = out_q ^ (mask_q & {OUT_W{phase_q}});
`ifdef PIO_PWM_EN
    led_d = blink_out & {OUT_W{pwm_q < duty_q}};
`else
    led_d = blink_out;
`endif
    irq_d = |(cap & irqm_q);

    rdata_d = rdata_q;
    if (bus.read) begin
      rdata_d = '0;
      case (bus.address)
        ADDR_DATA:               rdata_d[IN_W-1:0]  = sync;
        ADDR_SET, ADDR_CLEAR:    rdata_d[OUT_W-1:0] = out_q;
        ADDR_BLINK_MASK:         rdata_d[OUT_W-1:0] = mask_q;
        ADDR_BLINK_DIV:          rdata_d[DIV_W-1:0] = div_q;
        ADDR_IRQ_MASK:           rdata_d[IN_W-1:0]  = irqm_q;
        ADDR_EDGE_CAP:           rdata_d[IN_W-1:0]  = cap;
`ifdef PIO_PWM_EN
        ADDR_DUTY:               rdata_d[7:0]       = duty_q;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= RESET_OUT;
      mask_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      irqm_q  <= '0;
      led_q   <= RESET_OUT;
      irq_q   <= 1'b0;
      rdata_q <= '0;
`ifdef PIO_PWM_EN
      duty_q  <= 8'hFF;
      pwm_q   <= '0;
`endif
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      irqm_q  <= irqm_d;
      led_q   <= led_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
`ifdef PIO_PWM_EN
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign led          = led_q;
  assign irq          = irq_q;
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_pio_led_ctrl.sv
// Directed self-checking bench for pio_led_ctrl (RESET_OUT overridden to 0xA5).
module tb_pio_led_ctrl;
  import pio_led_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gpio_in = '0;
  logic [7:0] led;
  logic       irq;
  int         n_cmp = 0;
  int         n_err = 0;

  pio_led_ctrl_if bus_if ();

  pio_led_ctrl #(
    .OUT_W     (8),
    .IN_W      (4),
    .RESET_OUT (8'hA5),
    .EDGE_TYPE (EDGE_RISE),
    .DIV_W     (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if.slave),
    .gpio_in (gpio_in),
    .led     (led),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.address   = addr;
    bus_if.writedata = data;
    bus_if.write     = 1'b1;
    @(negedge clk);
    bus_if.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus_if.address = addr;
    bus_if.read    = 1'b1;
    @(negedge clk);
    bus_if.read    = 1'b0;
    data = bus_if.readdata;
  endtask

  logic [31:0] rd;
  logic [7:0]  acc;
  int          hi_cnt;

  initial begin
    bus_if.address   = '0;
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.writedata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_led", {24'd0, led}, 32'hA5);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_rdata", bus_if.readdata, 32'd0);
    rst = 1'b0;

    bus_read(ADDR_SET, rd);
    check_eq("rd_out_reset", rd, 32'hA5);

    // set/clear
    bus_write(ADDR_DATA, 32'h0F);
    bus_write(ADDR_SET, 32'h30);
    bus_write(ADDR_CLEAR, 32'h03);
    check_eq("led_lag", {24'd0, led}, 32'h3F);
    @(negedge clk);
    check_eq("led_setclr", {24'd0, led}, 32'h3C);
    bus_read(ADDR_SET, rd);
    check_eq("rd_setclr", rd, 32'h3C);
    bus_read(ADDR_CLEAR, rd);
    check_eq("rd_clr_addr", rd, 32'h3C);
    bus_read(ADDR_DATA, rd);
    check_eq("rd_data_in", rd, 32'h0);
    bus_read(ADDR_DUTY, rd);
`ifdef PIO_PWM_EN
    check_eq("rd_duty_rst", rd, 32'hFF);
`else
    check_eq("rd_addr7", rd, 32'h0);
`endif

    // blink: phase toggles every 4 cycles, led trails phase by one cycle
    bus_write(ADDR_CLEAR, 32'hFF);
    bus_write(ADDR_BLINK_MASK, 32'h01);
    bus_write(ADDR_BLINK_DIV, 32'd4);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check_eq($sformatf("blink_%0d", i), {24'd0, led}, (((i - 1) / 4) % 2 == 1) ? 32'h1 : 32'h0);
    end
    bus_write(ADDR_BLINK_DIV, 32'd0);
    @(negedge clk);
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc = acc | led;
    end
    check_eq("blink_off", {24'd0, acc}, 32'h0);
    bus_read(ADDR_BLINK_DIV, rd);
    check_eq("rd_div", rd, 32'h0);
    bus_read(ADDR_BLINK_MASK, rd);
    check_eq("rd_mask", rd, 32'h1);

    // edge capture / irq: capture on 3rd edge, irq on 4th
    bus_write(ADDR_IRQ_MASK, 32'h1);
    bus_read(ADDR_IRQ_MASK, rd);
    check_eq("rd_irqmask", rd, 32'h1);
    @(negedge clk);
    gpio_in = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("irq_lat_%0d", i), {31'd0, irq}, (i >= 4) ? 32'h1 : 32'h0);
    end
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("cap_rise0", rd, 32'h1);
    gpio_in = 4'b0000;
    repeat (5) @(negedge clk);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("cap_nofall", rd, 32'h1);
    bus_write(ADDR_EDGE_CAP, 32'h1);
    @(negedge clk);
    check_eq("irq_cleared", {31'd0, irq}, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("cap_cleared", rd, 32'h0);

    gpio_in = 4'b0010;
    repeat (6) @(negedge clk);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("cap_rise1", rd, 32'h2);
    check_eq("irq_masked", {31'd0, irq}, 32'h0);
    bus_read(ADDR_DATA, rd);
    check_eq("rd_sync", rd, 32'h2);

    // W1C of bit 0 lands on the same edge that captures a new bit-0 edge
    @(negedge clk);
    gpio_in = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    bus_if.address   = ADDR_EDGE_CAP;
    bus_if.writedata = 32'h1;
    bus_if.write     = 1'b1;
    @(negedge clk);
    bus_if.write     = 1'b0;
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("cap_conflict", rd, 32'h3);
    bus_write(ADDR_EDGE_CAP, 32'h3);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("cap_w1c_all", rd, 32'h0);

    // read and write to the same address in one cycle returns the old value
    @(negedge clk);
    bus_if.address   = ADDR_BLINK_MASK;
    bus_if.writedata = 32'h5A;
    bus_if.read      = 1'b1;
    bus_if.write     = 1'b1;
    @(negedge clk);
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    check_eq("rw_same", bus_if.readdata, 32'h1);
    bus_read(ADDR_BLINK_MASK, rd);
    check_eq("rw_after", rd, 32'h5A);

    // reset mid-blink with irq asserted
    bus_write(ADDR_IRQ_MASK, 32'h4);
    gpio_in = 4'b0111;
    repeat (5) @(negedge clk);
    gpio_in = 4'b0000;
    bus_write(ADDR_BLINK_DIV, 32'd2);
    repeat (5) @(negedge clk);
    check_eq("irq_pre_rst", {31'd0, irq}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_led", {24'd0, led}, 32'hA5);
    check_eq("midrst_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(ADDR_SET, rd);
    check_eq("post_rst_out", rd, 32'hA5);
    bus_read(ADDR_BLINK_MASK, rd);
    check_eq("post_rst_mask", rd, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("post_rst_cap", rd, 32'h0);
    check_eq("post_rst_led", {24'd0, led}, 32'hA5);

`ifdef PIO_PWM_EN
    bus_write(ADDR_DATA, 32'hFF);
    bus_write(ADDR_DUTY, 32'h40);
    bus_read(ADDR_DUTY, rd);
    check_eq("rd_duty", rd, 32'h40);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led == 8'hFF) hi_cnt++;
    end
    check_eq("pwm_64", hi_cnt, 32'd64);
    bus_write(ADDR_DUTY, 32'h00);
    @(negedge clk);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led != 8'h00) hi_cnt++;
    end
    check_eq("pwm_off", hi_cnt, 32'd0);
`else
    hi_cnt = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
